// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Central sequencer for a 5-stage pipeline. It drives the PC and pipeline
// register enables and flushes, and issues the data-memory request. Three
// hazard classes are resolved, highest priority first:
//   1. data-memory wait stall (owns a RUN/WAIT FSM with a timeout)
//   2. taken-branch flush of IF/ID and ID/EX
//   3. load-use stall (one bubble into ID/EX)
// All control outputs are combinational from the FSM state and the current
// inputs, so a hazard is answered in the same cycle it appears.
//
// Parameters:
//   TIMEOUT  maximum WAIT cycles before an access is abandoned (1..2^TO_W-1)
//   TO_W     width of the timeout counter
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   id_rs, id_rt        source register fields of the instruction in ID
//   id_uses_rt          ID instruction actually reads rt
//   ex_memread, ex_rd   EX instruction is a load, and its destination
//   ex_branch_taken     branch/jump resolved taken in EX
//   mem_access          MEM instruction performs a load or store
//   mem_ready           data memory completes the access this cycle
//   mem_req             data-memory request
//   pc_en .. memwb_en   PC and pipeline register enables
//   ifid_flush          IF/ID loads a bubble
//   idex_flush          ID/EX loads a bubble
//   memwb_bubble        MEM/WB loads a bubble instead of MEM results
//   mem_err             sticky timeout flag, cleared only by reset
//
// Optional feature (macro STALL_CNT_EN):
//   When defined, adds output stall_count[31:0], a saturating count of the
//   cycles (outside reset) in which pc_en=0 or any flush/bubble is asserted.
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       ex_memread,
    input  logic [4:0] ex_rd,
    input  logic       ex_branch_taken,
    input  logic       mem_access,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       pc_en,
    output logic       ifid_en,
    output logic       idex_en,
    output logic       exmem_en,
    output logic       memwb_en,
    output logic       ifid_flush,
    output logic       idex_flush,
    output logic       memwb_bubble,
    output logic       mem_err
`ifdef STALL_CNT_EN
    ,
    output logic [31:0] stall_count
`endif
);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            mem_err_q, mem_err_d;

    logic load_use;
    logic timeout_hit;
    logic mem_miss;

    // Register 0 is hard-wired, so a load targeting it never creates a hazard.
    assign load_use = ex_memread && (ex_rd != 5'd0) &&
                      ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

    assign timeout_hit = (to_cnt_q == TO_W'(TIMEOUT - 1));
    assign mem_miss    = mem_access && !mem_ready;

    // ---- state register ----
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_RUN;
            to_cnt_q  <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            to_cnt_q  <= to_cnt_d;
            mem_err_q <= mem_err_d;
        end
    end

    // ---- next-state logic ----
    always_comb begin
        state_d   = state_q;
        to_cnt_d  = to_cnt_q;
        mem_err_d = mem_err_q;
        case (state_q)
            S_RUN: begin
                if (mem_miss) begin
                    state_d  = S_WAIT;
                    to_cnt_d = '0;
                end
            end
            S_WAIT: begin
                // A ready on the last allowed cycle still completes the access.
                if (mem_ready) begin
                    state_d = S_RUN;
                end else if (timeout_hit) begin
                    state_d   = S_RUN;
                    mem_err_d = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    // ---- output logic ----
    always_comb begin
        mem_req      = mem_access;
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        idex_en      = 1'b1;
        exmem_en     = 1'b1;
        memwb_en     = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        memwb_bubble = 1'b0;

        if (reset) begin
            mem_req      = 1'b0;
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_en     = 1'b0;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            memwb_bubble = 1'b1;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (mem_miss) begin
                        // Freeze everything upstream of MEM; WB keeps draining
                        // but receives a bubble.
                        pc_en        = 1'b0;
                        ifid_en      = 1'b0;
                        idex_en      = 1'b0;
                        exmem_en     = 1'b0;
                        memwb_bubble = 1'b1;
                    end else if (ex_branch_taken) begin
                        // Branch beats load-use: the ID instruction is wrong-path.
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (load_use) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                    end
                end
                S_WAIT: begin
                    // Branch and load-use are masked here; their inputs stay
                    // frozen and are honoured once back in RUN.
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        memwb_bubble = 1'b0;
                    end else if (timeout_hit) begin
                        // Abandon the access: release the pipe, drop the data.
                        memwb_bubble = 1'b1;
                    end else begin
                        pc_en        = 1'b0;
                        ifid_en      = 1'b0;
                        idex_en      = 1'b0;
                        exmem_en     = 1'b0;
                        memwb_bubble = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_err = mem_err_q;

`ifdef STALL_CNT_EN
    logic [31:0] stall_cnt_q;
    logic        stall_event;

    assign stall_event = !reset &&
                         (!pc_en || ifid_flush || idex_flush || memwb_bubble);

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (stall_event && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Self-checking bench for pipe_hazard_ctrl, built with TIMEOUT=4 so the
// memory timeout is reachable in a few cycles. Directed scenarios use
// literal expected control vectors; the randomized scenario uses a
// behavioural reference model of the hazard rules.
// Output vector order:
//   {mem_req, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
//    ifid_flush, idex_flush, memwb_bubble, mem_err}
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    localparam int TIMEOUT = 4;
    localparam int TO_W    = 3;

    localparam logic [9:0] K_IDLE     = 10'b0_11111_000_0;
    localparam logic [9:0] K_IDLE_REQ = 10'b1_11111_000_0;
    localparam logic [9:0] K_RST      = 10'b0_00000_111_0;
    localparam logic [9:0] K_LU       = 10'b0_00111_010_0;
    localparam logic [9:0] K_LU_REQ   = 10'b1_00111_010_0;
    localparam logic [9:0] K_BR       = 10'b0_11111_110_0;
    localparam logic [9:0] K_BR_REQ   = 10'b1_11111_110_0;
    localparam logic [9:0] K_FRZ      = 10'b1_00001_001_0;
    localparam logic [9:0] K_TO       = 10'b1_11111_001_0;
    localparam logic [9:0] K_ERR      = 10'b0_00000_000_1;

    logic       clk;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_rd;
    logic       id_uses_rt, ex_memread, ex_branch_taken, mem_access, mem_ready;
    logic       mem_req, pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic       ifid_flush, idex_flush, memwb_bubble, mem_err;
`ifdef STALL_CNT_EN
    logic [31:0] stall_count;
`endif
    logic [9:0] outs;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: are we waiting on memory, how many WAIT cycles
    // have elapsed, sticky error, and number of stalled/flushed cycles.
    bit     m_wait   = 0;
    int     m_waited = 0;
    bit     m_err    = 0;
    longint m_stalls = 0;

    pipe_hazard_ctrl #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_uses_rt     (id_uses_rt),
        .ex_memread     (ex_memread),
        .ex_rd          (ex_rd),
        .ex_branch_taken(ex_branch_taken),
        .mem_access     (mem_access),
        .mem_ready      (mem_ready),
        .mem_req        (mem_req),
        .pc_en          (pc_en),
        .ifid_en        (ifid_en),
        .idex_en        (idex_en),
        .exmem_en       (exmem_en),
        .memwb_en       (memwb_en),
        .ifid_flush     (ifid_flush),
        .idex_flush     (idex_flush),
        .memwb_bubble   (memwb_bubble),
        .mem_err        (mem_err)
`ifdef STALL_CNT_EN
        ,
        .stall_count    (stall_count)
`endif
    );

    assign outs = {mem_req, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                   ifid_flush, idex_flush, memwb_bubble, mem_err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected control vector for the current inputs and model state.
    function automatic logic [9:0] model_out();
        logic [9:0] e;
        bit         lu;
        lu = ex_memread && (ex_rd != 5'd0) &&
             ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
        if (reset)
            e = K_RST;
        else if (m_wait) begin
            if (mem_ready)                   e = K_IDLE_REQ;
            else if (m_waited == TIMEOUT - 1) e = K_TO;
            else                             e = K_FRZ;
        end else if (mem_access && !mem_ready)
            e = K_FRZ;
        else if (ex_branch_taken)
            e = mem_access ? K_BR_REQ : K_BR;
        else if (lu)
            e = mem_access ? K_LU_REQ : K_LU;
        else
            e = mem_access ? K_IDLE_REQ : K_IDLE;
        e[0] = m_err;
        return e;
    endfunction

    // Advance one clock and move the reference model along with it.
    task automatic tick();
        logic [9:0] e;
        @(posedge clk);
        e = model_out();
        if (reset) begin
            m_wait = 0; m_waited = 0; m_err = 0; m_stalls = 0;
        end else begin
            if (!e[8] || e[3] || e[2] || e[1]) m_stalls++;
            if (!m_wait) begin
                if (mem_access && !mem_ready) begin
                    m_wait = 1; m_waited = 0;
                end
            end else if (mem_ready) begin
                m_wait = 0;
            end else if (m_waited == TIMEOUT - 1) begin
                m_wait = 0; m_err = 1;
            end else begin
                m_waited++;
            end
        end
        #1;
    endtask

    task automatic clear_in();
        id_rs = 0; id_rt = 0; ex_rd = 0; id_uses_rt = 0; ex_memread = 0;
        ex_branch_taken = 0; mem_access = 0; mem_ready = 0;
    endtask

    task automatic test_reset();
        logic [9:0] exp;
        clear_in();
        reset = 1;
        tick();
        for (int i = 0; i < 4; i++) begin
            reset = (i < 3);
            exp = (i < 3) ? K_RST : K_IDLE;
            @(negedge clk); n_tests++;
            if (outs !== exp) begin
                n_fail++;
                $display("FAIL reset cycle %0d: got %b expected %b", i, outs, exp);
            end
            tick();
        end
    endtask

    task automatic test_load_use();
        logic [9:0] exp;
        for (int i = 0; i < 5; i++) begin
            clear_in();
            exp = K_IDLE;
            case (i)
                0: begin ex_memread = 1; ex_rd = 5; id_rs = 5; exp = K_LU; end
                1: exp = K_IDLE;
                2: begin ex_memread = 1; ex_rd = 0; id_rs = 0; exp = K_IDLE; end
                3: begin ex_memread = 1; ex_rd = 9; id_rt = 9; id_rs = 3;
                         id_uses_rt = 1; exp = K_LU; end
                default: begin ex_memread = 1; ex_rd = 9; id_rt = 9; id_rs = 3;
                         id_uses_rt = 0; exp = K_IDLE; end
            endcase
            @(negedge clk); n_tests++;
            if (outs !== exp) begin
                n_fail++;
                $display("FAIL load_use step %0d: got %b expected %b", i, outs, exp);
            end
            tick();
        end
    endtask

    task automatic test_mem_stall();
        logic [9:0] exp;
        for (int i = 0; i < 7; i++) begin
            clear_in();
            if (i < 4) begin
                mem_access = 1; mem_ready = 0; ex_branch_taken = (i >= 1);
                exp = K_FRZ;
            end else if (i == 4) begin
                mem_access = 1; mem_ready = 1; ex_branch_taken = 1;
                exp = K_IDLE_REQ;
            end else if (i == 5) begin
                ex_branch_taken = 1; exp = K_BR;
            end else begin
                exp = K_IDLE;
            end
            @(negedge clk); n_tests++;
            if (outs !== exp) begin
                n_fail++;
                $display("FAIL mem_stall step %0d: got %b expected %b", i, outs, exp);
            end
            tick();
        end
    endtask

    task automatic test_branch_vs_load_use();
        logic [9:0] exp;
        for (int i = 0; i < 4; i++) begin
            clear_in();
            ex_memread = (i < 3); ex_rd = 7; id_rs = 7;
            case (i)
                0: begin ex_branch_taken = 1; exp = K_BR; end
                1: begin ex_branch_taken = 1; mem_access = 1; mem_ready = 1;
                         exp = K_BR_REQ; end
                2: begin mem_access = 1; mem_ready = 1; exp = K_LU_REQ; end
                default: begin mem_ready = 1; exp = K_IDLE; end
            endcase
            @(negedge clk); n_tests++;
            if (outs !== exp) begin
                n_fail++;
                $display("FAIL branch_vs_lu step %0d: got %b expected %b", i, outs, exp);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [9:0] exp;
        for (int i = 0; i < 5; i++) begin
            clear_in();
            reset = (i == 2);
            case (i)
                0, 1: begin mem_access = 1; exp = K_FRZ; end
                2: begin mem_access = 1; exp = K_RST; end
                3: begin mem_ready = 1; exp = K_IDLE; end
                default: begin mem_access = 1; mem_ready = 1; exp = K_IDLE_REQ; end
            endcase
            @(negedge clk); n_tests++;
            if (outs !== exp) begin
                n_fail++;
                $display("FAIL reset_mid_wait step %0d: got %b expected %b", i, outs, exp);
            end
            tick();
        end
        reset = 0;
    endtask

    task automatic test_timeout();
        logic [9:0] exp;
        for (int i = 0; i < 9; i++) begin
            clear_in();
            reset = (i == 7);
            if (i < 5) mem_access = 1;
            case (i)
                0, 1, 2, 3: exp = K_FRZ;
                4:          exp = K_TO;
                5, 6:       exp = K_IDLE | K_ERR;
                7:          exp = K_RST | K_ERR;
                default:    exp = K_IDLE;
            endcase
            @(negedge clk); n_tests++;
            if (outs !== exp) begin
                n_fail++;
                $display("FAIL timeout step %0d: got %b expected %b", i, outs, exp);
            end
            tick();
        end
        reset = 0;
    endtask

`ifdef STALL_CNT_EN
    task automatic test_stall_count();
        clear_in();
        reset = 1;
        tick();
        reset = 0;
        @(negedge clk); n_tests++;
        if (stall_count !== 32'd0) begin
            n_fail++;
            $display("FAIL stall_count_reset: got %0d expected 0", stall_count);
        end
        for (int i = 0; i < 10; i++) begin
            clear_in();
            case (i)
                0: begin ex_memread = 1; ex_rd = 4; id_rs = 4; end
                2: ex_branch_taken = 1;
                4, 5, 6, 7: mem_access = 1;
                8: begin mem_access = 1; mem_ready = 1; end
                default: ;
            endcase
            tick();
        end
        @(negedge clk); n_tests++;
        if (stall_count !== 32'd6) begin
            n_fail++;
            $display("FAIL stall_count_total: got %0d expected 6", stall_count);
        end
    endtask
`endif

    task automatic test_random();
        logic [9:0] exp;
        for (int i = 0; i < 3000; i++) begin
            reset           = ($urandom_range(63) == 0);
            id_rs           = 5'($urandom_range(3));
            id_rt           = 5'($urandom_range(3));
            ex_rd           = 5'($urandom_range(3));
            id_uses_rt      = 1'($urandom_range(1));
            ex_memread      = 1'($urandom_range(1));
            ex_branch_taken = ($urandom_range(3) == 0);
            mem_access      = ($urandom_range(2) == 0);
            mem_ready       = 1'($urandom_range(1));
            @(negedge clk);
            exp = model_out();
            n_tests++;
            if (outs !== exp) begin
                n_fail++;
                $display("FAIL random cycle %0d: got %b expected %b", i, outs, exp);
            end
`ifdef STALL_CNT_EN
            n_tests++;
            if (stall_count !== m_stalls[31:0]) begin
                n_fail++;
                $display("FAIL random stall_count cycle %0d: got %0d expected %0d",
                         i, stall_count, m_stalls[31:0]);
            end
`endif
            tick();
        end
        clear_in();
        reset = 0;
    endtask

    initial begin
        reset = 1;
        clear_in();
        test_reset();
        test_load_use();
        test_mem_stall();
        test_branch_vs_load_use();
        test_reset_mid_wait();
        test_timeout();
`ifdef STALL_CNT_EN
        test_stall_count();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
